// File: rtl/logic_unit_pipe.sv
// Two-stage valid/ready pipeline applying one of eight bitwise gate ops to two operands.
// Define LOGIC_UNIT_PIPE_REDUCE_EN to register {xor,or,and}-reductions of the result on out_red.
module logic_unit_pipe #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [2:0]       in_op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_res,
   output logic [2:0]       out_red,
   output logic [CNT_W-1:0] op_count
);

   logic [WIDTH-1:0] a_q, b_q;
   logic [2:0]       op_q;
   logic             va_q;
   logic [WIDTH-1:0] res_q, res_d;
   logic             vb_q;
   logic [CNT_W-1:0] cnt_q;

   logic rdy_b, in_xfer, out_xfer, adv_a;

   assign rdy_b    = !vb_q || out_ready;
   assign in_ready = !va_q || rdy_b;
   assign in_xfer  = in_valid && in_ready;
   assign out_xfer = vb_q && out_ready;
   assign adv_a    = va_q && rdy_b;

   always_comb begin
      res_d = '0;
      case (op_q)
         3'd0: res_d = a_q & b_q;
         3'd1: res_d = a_q | b_q;
         3'd2: res_d = ~(a_q & b_q);
         3'd3: res_d = ~(a_q | b_q);
         3'd4: res_d = a_q ^ b_q;
         3'd5: res_d = ~(a_q ^ b_q);
         3'd6: res_d = ~a_q;
         3'd7: res_d = ~b_q;
         default: res_d = '0;
      endcase
   end

   // Stage A
   always_ff @(posedge clk) begin
      if (rst) begin
         a_q  <= '0;
         b_q  <= '0;
         op_q <= '0;
         va_q <= 1'b0;
      end else begin
         if (in_xfer) begin
            a_q  <= in_a;
            b_q  <= in_b;
            op_q <= in_op;
            va_q <= 1'b1;
         end else if (adv_a) begin
            va_q <= 1'b0;
         end
      end
   end

   // Stage B and transfer counter
   always_ff @(posedge clk) begin
      if (rst) begin
         res_q <= '0;
         vb_q  <= 1'b0;
         cnt_q <= '0;
      end else begin
         if (adv_a) begin
            res_q <= res_d;
            vb_q  <= 1'b1;
         end else if (out_xfer) begin
            vb_q <= 1'b0;
         end
         if (out_xfer) begin
            cnt_q <= cnt_q + CNT_W'(1);
         end
      end
   end

`ifdef LOGIC_UNIT_PIPE_REDUCE_EN
   logic [2:0] red_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         red_q <= 3'b000;
      end else if (adv_a) begin
         red_q <= {^res_d, |res_d, &res_d};
      end
   end

   assign out_red = red_q;
`else
   assign out_red = 3'b000;
`endif

   assign out_valid = vb_q;
   assign out_res   = res_q;
   assign op_count  = cnt_q;

endmodule
